bus_arb2: RTL and testbench

BUS_ARB2 -- requirements
Module: bus_arb2

---
 rtl/bus_arb2.sv | 132 +++++++++++++
 tb/tb_bus_arb2.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arb2.sv
// Two-master to one-slave bus arbiter with round-robin tie-break and a
// per-transaction grant timeout that returns an error response.
module bus_arb2 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_req,
    output logic [31:0] s_addr,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        own_gnt, own_rvalid, own_err;
    logic [31:0] own_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        s_req      = 1'b0;
        s_addr     = 32'd0;
        s_we       = 1'b0;
        s_be       = 4'd0;
        s_wdata    = 32'd0;
        own_gnt    = 1'b0;
        own_rvalid = 1'b0;
        own_rdata  = 32'd0;
        own_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // On a tie the master not served last wins.
                    owner_d = (m0_req && m1_req) ? ~last_q : m1_req;
                    state_d = REQ;
                    cnt_d   = 8'd0;
                end
            end
            REQ: begin
                s_req   = 1'b1;
                s_addr  = owner_q ? m1_addr  : m0_addr;
                s_we    = owner_q ? m1_we    : m0_we;
                s_be    = owner_q ? m1_be    : m0_be;
                s_wdata = owner_q ? m1_wdata : m0_wdata;
                own_gnt = s_gnt;
                if (s_gnt) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TO_LAST) begin
                        own_gnt = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            RESP: begin
                own_rvalid = s_rvalid;
                own_rdata  = s_rdata;
                if (s_rvalid) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            ERR: begin
                own_rvalid = 1'b1;
                own_rdata  = ERR_DATA;
                own_err    = 1'b1;
                last_d     = owner_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Non-owner outputs are forced to zero.
    assign m0_gnt    = own_gnt    & ~owner_q;
    assign m0_rvalid = own_rvalid & ~owner_q;
    assign m0_err    = own_err    & ~owner_q;
    assign m0_rdata  = owner_q ? 32'd0 : own_rdata;
    assign m1_gnt    = own_gnt    & owner_q;
    assign m1_rvalid = own_rvalid & owner_q;
    assign m1_err    = own_err    & owner_q;
    assign m1_rdata  = owner_q ? own_rdata : 32'd0;

endmodule

// File: tb/tb_bus_arb2.sv
// Scoreboard bench for bus_arb2: latency, tie-break alternation, write fields,
// timeout error response, mid-transaction reset and spurious slave strobes.
module tb_bus_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int          m;
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    // slave model controls
    logic        slave_en = 1'b1;
    logic        spur_gnt = 1'b0;
    logic        spur_rv  = 1'b0;
    logic [31:0] rkey     = 32'h5A5A_0000;
    logic        sreq_prev = 1'b0;
    logic        gnt_prev  = 1'b0;
    logic [31:0] addr_prev = 32'd0;

    bus_arb2 #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic any_out();
        return |{m0_gnt, m0_rvalid, m0_rdata, m0_err, m1_gnt, m1_rvalid, m1_rdata, m1_err,
                 s_req, s_addr, s_we, s_be, s_wdata};
    endfunction

    // Slave: grants in the second cycle of s_req, responds one cycle after s_gnt.
    always @(negedge clk) begin
        sreq_prev = s_req;
        gnt_prev  = s_gnt && s_req;
        addr_prev = s_addr;
    end

    initial begin
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            s_gnt    = (slave_en && s_req && sreq_prev) || spur_gnt;
            s_rvalid = gnt_prev || spur_rv;
            s_rdata  = gnt_prev ? (addr_prev ^ rkey) : 32'd0;
        end
    end

    // Response monitor: pops the scoreboard on every rvalid.
    always @(negedge clk) begin
        if (m0_rvalid || m1_rvalid) begin
            check("rvalid_onehot", {31'd0, m0_rvalid && m1_rvalid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_master", m1_rvalid ? 32'd1 : 32'd0, e.m);
                if (m1_rvalid) begin
                    check("m1_rdata", m1_rdata, e.rd);
                    check("m1_err", {31'd0, m1_err}, {31'd0, e.err});
                    check("m0_idle_outs", {31'd0, |{m0_gnt, m0_rvalid, m0_rdata, m0_err}}, 32'd0);
                end else begin
                    check("m0_rdata", m0_rdata, e.rd);
                    check("m0_err", {31'd0, m0_err}, {31'd0, e.err});
                    check("m1_idle_outs", {31'd0, |{m1_gnt, m1_rvalid, m1_rdata, m1_err}}, 32'd0);
                end
            end
        end
    end

    task automatic drive_req(input int m, input logic v, input logic [31:0] a,
                             input logic we, input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            m0_req = v; m0_addr = a; m0_we = we; m0_be = be; m0_wdata = wd;
        end else begin
            m1_req = v; m1_addr = a; m1_we = we; m1_be = be; m1_wdata = wd;
        end
    endtask

    // One transaction; cycle 0 is the cycle the request is first seen in IDLE.
    task automatic txn(input string tag, input int m, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_gnt_c, input int exp_rv_c);
        exp_t e;
        int   c = 0, sreq_c = -1, gnt_c = -1, rv_c = -1;
        e.m = m; e.rd = exp_rd; e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk); #1;
        drive_req(m, 1'b1, a, we, be, wd);
        while (rv_c < 0 && c < 100) begin
            @(negedge clk);
            if (s_req && sreq_c < 0) begin
                sreq_c = c;
                check({tag, "_s_addr"}, s_addr, a);
                check({tag, "_s_we"}, {31'd0, s_we}, {31'd0, we});
                check({tag, "_s_be"}, {28'd0, s_be}, {28'd0, be});
                check({tag, "_s_wdata"}, s_wdata, wd);
            end
            if ((m == 0 ? m0_gnt : m1_gnt) && gnt_c < 0) gnt_c = c;
            if (m == 0 ? m0_rvalid : m1_rvalid) rv_c = c;
            c++;
            if (gnt_c == c - 1) begin
                @(posedge clk); #1;
                drive_req(m, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
            end
        end
        check({tag, "_sreq_cyc"}, sreq_c, 1);
        check({tag, "_gnt_cyc"}, gnt_c, exp_gnt_c);
        check({tag, "_rv_cyc"}, rv_c, exp_rv_c);
        @(negedge clk);
        check({tag, "_after_outs"}, {31'd0, any_out()}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_outs", {31'd0, any_out()}, 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        int g_cnt, c;
        rst = 1'b0;
        drive_req(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive_req(1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        #1 check("por_outs", {31'd0, any_out()}, 32'd0);
        do_reset();

        // m0 read alone
        rkey = 32'h12345678 ^ 32'h00002010;
        txn("rd0", 0, 32'h00002010, 1'b0, 4'hF, 32'd0, 32'h12345678, 1'b0, 2, 3);
        rkey = 32'h5A5A_0000;

        // m1 write
        txn("wr1", 1, 32'h00000040, 1'b1, 4'b0101, 32'hAABBCCDD,
            32'h00000040 ^ 32'h5A5A_0000, 1'b0, 2, 3);

        // timeout: no slave grant
        slave_en = 1'b0;
        txn("tmo", 0, 32'h00005000, 1'b0, 4'hF, 32'd0, 32'hDEADBEEF, 1'b1, 15, 16);
        slave_en = 1'b1;

        // alternation after reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.m   = i % 2;
            e.rd  = (i % 2 == 0 ? 32'h00000100 : 32'h00000200) ^ 32'h5A5A_0000;
            e.err = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        drive_req(0, 1'b1, 32'h00000100, 1'b0, 4'hF, 32'd0);
        drive_req(1, 1'b1, 32'h00000200, 1'b0, 4'hF, 32'd0);
        g_cnt = 0; c = 0;
        while (g_cnt < 8 && c < 200) begin
            @(negedge clk);
            c++;
            if (m0_gnt || m1_gnt) begin
                check("alt_order", m1_gnt ? 32'd1 : 32'd0, g_cnt % 2);
                g_cnt++;
            end
        end
        check("alt_grants", g_cnt, 8);
        @(posedge clk); #1;
        drive_req(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive_req(1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        c = 0;
        while (exp_q.size() != 0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("alt_drained", exp_q.size(), 0);

        // reset in RESP
        @(posedge clk); #1;
        drive_req(0, 1'b1, 32'h00000300, 1'b0, 4'hF, 32'd0);
        c = 0;
        while (!m0_gnt && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("rst_pre_gnt", {31'd0, m0_gnt}, 32'd1);
        @(posedge clk); #2;
        check("rst_pre_rvalid", {31'd0, m0_rvalid}, 32'd1);
        rst = 1'b0;
        #1 check("rst_async_outs", {31'd0, any_out()}, 32'd0);
        drive_req(0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        spur_rv = 1'b1;
        @(posedge clk); #2;
        spur_rv = 1'b0;
        @(negedge clk);
        check("stale_rv_ignored", {31'd0, m0_rvalid | m1_rvalid | m0_gnt | m1_gnt}, 32'd0);
        txn("post_rst", 1, 32'h00000400, 1'b0, 4'hF, 32'd0,
            32'h00000400 ^ 32'h5A5A_0000, 1'b0, 2, 3);

        // spurious slave strobes in IDLE
        @(posedge clk); #2;
        spur_gnt = 1'b1;
        @(posedge clk); #2;
        spur_gnt = 1'b0;
        spur_rv  = 1'b1;
        @(posedge clk); #2;
        spur_rv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("spur_outs", {31'd0, any_out()}, 32'd0);
        end
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
